id_ex_pipeline_reg: RTL and testbench
=====================================

Name: id_ex_pipeline_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline.
- Captures decoded operands and control from ID.
- Supplies the EX stage, and the Rs/Rt/Rdest/RegWrite fields consumed by the forwarding unit.
- Detects load-use hazards, inserts bubbles, holds on memory wait, applies branch flushes, and counts stall events.

Parameters:
- ALU_OP_W, 4, width of ALU operation code
- CNT_W, 16, width of saturating performance counters

Ports:
- clk in 1: pipeline clock
- rst in 1: asynchronous active-high reset
- id_valid in 1: ID holds a real instruction
- id_rs in 5: source register s
- id_rt in 5: source register t
- id_rdest in 5: destination register after RegDst mux
- id_uses_rs in 1: instruction reads Rs
- id_uses_rt in 1: instruction reads Rt
- id_read_data1 in 32: register file port 1
- id_read_data2 in 32: register file port 2
- id_imm in 32: sign/zero-extended immediate
- id_pc in 32: instruction PC
- id_regwrite in 1: control bit
- id_memread in 1: control bit
- id_memwrite in 1: control bit
- id_memtoreg in 1: control bit
- id_alu_op in ALU_OP_W: control field
- flush in 1: branch/jump redirect; squash ID instruction
- mem_stall in 1: data-memory waitrequest; freeze pipeline
- ID_EX_valid out 1: EX holds real instruction
- ID_EX_Rs out 5
- ID_EX_Rt out 5
- ID_EX_Rdest out 5
- ID_EX_read_data1 out 32
- ID_EX_read_data2 out 32
- ID_EX_imm out 32
- ID_EX_pc out 32
- ID_EX_RegWrite out 1
- ID_EX_MemRead out 1
- ID_EX_MemWrite out 1
- ID_EX_MemtoReg out 1
- ID_EX_alu_op out ALU_OP_W
- hold_upstream out 1: freeze PC and IF/ID this cycle
- load_use_count out CNT_W: bubbles inserted, saturating
- mem_stall_count out CNT_W: cycles frozen by mem_stall, saturating

Behaviour:
- Reset (async, rst=1): every registered output is 0 and pending_flush=0. This is a bubble.
  - Released synchronously on the first clk edge with rst=0.
  - Reset mid-stall discards the held instruction and any pending flush.
- Bubble: valid, RegWrite, MemRead, MemWrite, MemtoReg, alu_op, Rs, Rt, Rdest and all data fields are 0. A bubble therefore never triggers forwarding.
- load_use (combinational):
  - Condition: ID_EX_valid & ID_EX_MemRead & ID_EX_Rdest!=0 & id_valid.
  - And at least one of: (id_uses_rs & id_rs==ID_EX_Rdest) or (id_uses_rt & id_rt==ID_EX_Rdest).
- hold_upstream = mem_stall | (load_use & !flush & !pending_flush). Combinational, 0-cycle latency.
- Per-edge priority, highest first:
  1. mem_stall=1:
     - All ID_EX_* outputs hold their value.
     - If flush=1, set pending_flush=1.
     - mem_stall_count += 1, saturating at all-ones.
  2. flush=1 or pending_flush=1:
     - Load a bubble and clear pending_flush.
     - load_use_count is unchanged, even if load_use is true.
  3. load_use=1:
     - Load a bubble; upstream holds, so the same ID instruction is re-presented next cycle.
     - load_use_count += 1, saturating.
  4. Otherwise: capture all id_* fields.
     - ID_EX_valid = id_valid.
     - If id_valid=0, the control bits and Rdest are forced to 0.
- Latency: one cycle from ID to ID_EX_* when none of the hold, flush or bubble conditions applies.
- A load-use bubble lasts exactly one cycle: after the bubble, ID_EX_MemRead=0, so load_use deasserts.
- Back-to-back loads each cause at most one bubble.
- Counters reset only by rst and never wrap.
- No output depends combinationally on data inputs, except hold_upstream.

Decomposition:
- Shared package mips_pipeline_pkg holds:
  - ALU opcode constants
  - the REG_ZERO=5'd0 constant
  - a packed id_ex_ctrl_t struct {regwrite, memread, memwrite, memtoreg, alu_op}, reused by the EX/MEM register.
- One natural sub-module: sat_counter (parameter CNT_W, inputs inc and rst), instantiated twice.
- Load-use detection stays inline.

Test Plan:
- Plain capture:
  - Stimulus: id_valid=1, rs=3, rt=4, rdest=5, regwrite=1, data1=0x11, imm=0x20; no flush or stall.
  - Response: the next cycle shows ID_EX_Rs=3, Rt=4, Rdest=5, RegWrite=1, read_data1=0x11, imm=0x20; hold_upstream=0.
- Load-use bubble:
  - Stimulus: EX holds lw with Rdest=8; ID presents add with rs=8, uses_rs=1.
  - Response: hold_upstream=1 the same cycle; next cycle is a bubble (valid=0, Rdest=0); the cycle after captures the add; load_use_count=1.
- No false hazard:
  - Stimulus: EX lw with Rdest=0 and ID rs=0; separately, lw Rdest=8 with ID rt=8 but uses_rt=0.
  - Response: hold_upstream=0 and no bubble in either case.
- mem_stall with flush:
  - Stimulus: mem_stall=1 for 3 cycles, flush pulsed in the 2nd stall cycle.
  - Response: outputs frozen for 3 cycles; the first cycle after the stall loads a bubble; mem_stall_count=3; pending_flush then clears.
- Flush beats load_use:
  - Stimulus: load_use condition and flush=1 in the same cycle.
  - Response: hold_upstream=0, a bubble is loaded, load_use_count unchanged.
- Async reset:
  - Stimulus: assert rst between clock edges while outputs hold valid=1, RegWrite=1.
  - Response: all outputs 0 immediately, without waiting for a clk edge; with CNT_W=2, four load-use events then read load_use_count=3 (saturated).

Source files
------------

// File: rtl/id_ex_pipeline_reg_pkg.sv
// mips_pipeline_pkg: constants and types shared by the MIPS pipeline registers.
// Contents: ALU opcode constants, the zero-register index REG_ZERO, and the
// id_ex_ctrl_t control bundle that the EX/MEM register reuses.
package mips_pipeline_pkg;
    localparam int ALU_OP_W_DEF = 4;
    localparam logic [ALU_OP_W_DEF-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W_DEF-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W_DEF-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_W_DEF-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_W_DEF-1:0] ALU_SLT = 4'd4;
    localparam logic [4:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic                    regwrite;
        logic                    memread;
        logic                    memwrite;
        logic                    memtoreg;
        logic [ALU_OP_W_DEF-1:0] alu_op;
    } id_ex_ctrl_t;
endpackage

// File: rtl/id_ex_pipeline_reg_if.sv
// id_ex_pipeline_reg_if: signal bundle between the ID stage and the ID/EX register.
// master: the ID side, which drives the id_* fields plus flush and mem_stall,
//         and sees the ID_EX_* stage contents, hold_upstream and the counters.
// slave:  the ID/EX register itself.
interface id_ex_pipeline_reg_if #(
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 16
);
    logic                id_valid;
    logic [4:0]          id_rs;
    logic [4:0]          id_rt;
    logic [4:0]          id_rdest;
    logic                id_uses_rs;
    logic                id_uses_rt;
    logic [31:0]         id_read_data1;
    logic [31:0]         id_read_data2;
    logic [31:0]         id_imm;
    logic [31:0]         id_pc;
    logic                id_regwrite;
    logic                id_memread;
    logic                id_memwrite;
    logic                id_memtoreg;
    logic [ALU_OP_W-1:0] id_alu_op;
    logic                flush;
    logic                mem_stall;
    logic                ID_EX_valid;
    logic [4:0]          ID_EX_Rs;
    logic [4:0]          ID_EX_Rt;
    logic [4:0]          ID_EX_Rdest;
    logic [31:0]         ID_EX_read_data1;
    logic [31:0]         ID_EX_read_data2;
    logic [31:0]         ID_EX_imm;
    logic [31:0]         ID_EX_pc;
    logic                ID_EX_RegWrite;
    logic                ID_EX_MemRead;
    logic                ID_EX_MemWrite;
    logic                ID_EX_MemtoReg;
    logic [ALU_OP_W-1:0] ID_EX_alu_op;
    logic                hold_upstream;
    logic [CNT_W-1:0]    load_use_count;
    logic [CNT_W-1:0]    mem_stall_count;
    modport master (
        output id_valid, id_rs, id_rt, id_rdest, id_uses_rs, id_uses_rt,
               id_read_data1, id_read_data2, id_imm, id_pc,
               id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alu_op,
               flush, mem_stall,
        input  ID_EX_valid, ID_EX_Rs, ID_EX_Rt, ID_EX_Rdest,
               ID_EX_read_data1, ID_EX_read_data2, ID_EX_imm, ID_EX_pc,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_alu_op,
               hold_upstream, load_use_count, mem_stall_count
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_rdest, id_uses_rs, id_uses_rt,
               id_read_data1, id_read_data2, id_imm, id_pc,
               id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alu_op,
               flush, mem_stall,
        output ID_EX_valid, ID_EX_Rs, ID_EX_Rt, ID_EX_Rdest,
               ID_EX_read_data1, ID_EX_read_data2, ID_EX_imm, ID_EX_pc,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_alu_op,
               hold_upstream, load_use_count, mem_stall_count
    );
endinterface

// File: rtl/id_ex_pipeline_reg_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
// Ports: clk, rst (async active-high clear), inc (count this cycle), count_o (value).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q, count_d;
    always_comb count_d = (inc && count_q != '1) ? count_q + CNT_W'(1) : count_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
    assign count_o = count_q;
endmodule

// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: ID/EX register of the 5-stage MIPS pipeline.
// Ports: clk, rst (async active-high), bus (slave side of id_ex_pipeline_reg_if:
// id_* decode fields, flush, mem_stall in; ID_EX_* stage contents,
// hold_upstream and the two saturating stall counters out).
module id_ex_pipeline_reg
    import mips_pipeline_pkg::*;
#(
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 16
) (
    input logic                clk,
    input logic                rst,
    id_ex_pipeline_reg_if.slave bus
);
    typedef struct packed {
        logic                valid;
        logic [4:0]          rs;
        logic [4:0]          rt;
        logic [4:0]          rdest;
        logic [31:0]         rd1;
        logic [31:0]         rd2;
        logic [31:0]         imm;
        logic [31:0]         pc;
        logic                regwrite;
        logic                memread;
        logic                memwrite;
        logic                memtoreg;
        logic [ALU_OP_W-1:0] alu_op;
    } stage_t;
    stage_t stage_q, stage_d, capture;
    logic   pending_flush_q, pending_flush_d;
    logic   load_use, squash;
    // A load in EX whose result an ID instruction needs one cycle too early.
    // Rdest of zero never forwards, so it can never create a hazard.
    always_comb begin
        load_use = stage_q.valid & stage_q.memread & (stage_q.rdest != REG_ZERO) & bus.id_valid &
                   ((bus.id_uses_rs & (bus.id_rs == stage_q.rdest)) |
                    (bus.id_uses_rt & (bus.id_rt == stage_q.rdest)));
    end
    assign squash = bus.flush | pending_flush_q;
    // A squashed instruction need not be re-presented, so flushes cancel the load-use hold.
    assign bus.hold_upstream = bus.mem_stall | (load_use & ~squash);
    // An empty ID slot must not look like a writer to the forwarding unit.
    always_comb begin
        capture = '{
            valid:    bus.id_valid,
            rs:       bus.id_rs,
            rt:       bus.id_rt,
            rdest:    bus.id_valid ? bus.id_rdest : REG_ZERO,
            rd1:      bus.id_read_data1,
            rd2:      bus.id_read_data2,
            imm:      bus.id_imm,
            pc:       bus.id_pc,
            regwrite: bus.id_valid & bus.id_regwrite,
            memread:  bus.id_valid & bus.id_memread,
            memwrite: bus.id_valid & bus.id_memwrite,
            memtoreg: bus.id_valid & bus.id_memtoreg,
            alu_op:   bus.id_valid ? bus.id_alu_op : {ALU_OP_W{1'b0}}
        };
    end
    // Priority: memory freeze, then flush (live or remembered), then load-use bubble, then capture.
    always_comb begin
        stage_d         = bus.mem_stall ? stage_q : (squash | load_use) ? stage_t'('0) : capture;
        pending_flush_d = bus.mem_stall & (pending_flush_q | bus.flush);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q         <= '0;
            pending_flush_q <= 1'b0;
        end else begin
            stage_q         <= stage_d;
            pending_flush_q <= pending_flush_d;
        end
    end
    sat_counter #(.CNT_W(CNT_W)) u_load_use_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (~bus.mem_stall & ~squash & load_use),
        .count_o (bus.load_use_count)
    );
    sat_counter #(.CNT_W(CNT_W)) u_mem_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (bus.mem_stall),
        .count_o (bus.mem_stall_count)
    );
    assign bus.ID_EX_valid      = stage_q.valid;
    assign bus.ID_EX_Rs         = stage_q.rs;
    assign bus.ID_EX_Rt         = stage_q.rt;
    assign bus.ID_EX_Rdest      = stage_q.rdest;
    assign bus.ID_EX_read_data1 = stage_q.rd1;
    assign bus.ID_EX_read_data2 = stage_q.rd2;
    assign bus.ID_EX_imm        = stage_q.imm;
    assign bus.ID_EX_pc         = stage_q.pc;
    assign bus.ID_EX_RegWrite   = stage_q.regwrite;
    assign bus.ID_EX_MemRead    = stage_q.memread;
    assign bus.ID_EX_MemWrite   = stage_q.memwrite;
    assign bus.ID_EX_MemtoReg   = stage_q.memtoreg;
    assign bus.ID_EX_alu_op     = stage_q.alu_op;
endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb_id_ex_pipeline_reg: directed and random checks of id_ex_pipeline_reg against a rule-level model.
module tb_id_ex_pipeline_reg;
    import mips_pipeline_pkg::*;
    localparam int AW   = 4;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    id_ex_pipeline_reg_if #(.ALU_OP_W(AW), .CNT_W(CW)) bus();
    id_ex_pipeline_reg #(.ALU_OP_W(AW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct packed {
        logic          valid;
        logic [4:0]    rs, rt, rdest;
        logic [31:0]   d1, d2, imm, pc;
        logic          rw, mr, mw, mtr;
        logic [AW-1:0] alu;
    } ex_t;
    ex_t m;
    bit  m_pend;
    int  m_lu, m_ms;
    int  n_cmp = 0, n_err = 0;

    function automatic ex_t dut_ex();
        return {bus.ID_EX_valid, bus.ID_EX_Rs, bus.ID_EX_Rt, bus.ID_EX_Rdest,
                bus.ID_EX_read_data1, bus.ID_EX_read_data2, bus.ID_EX_imm, bus.ID_EX_pc,
                bus.ID_EX_RegWrite, bus.ID_EX_MemRead, bus.ID_EX_MemWrite, bus.ID_EX_MemtoReg,
                bus.ID_EX_alu_op};
    endfunction

    task automatic chk(input string tag, input logic [151:0] obs, input logic [151:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m = '0;
        m_pend = 0;
        m_lu = 0;
        m_ms = 0;
    endtask

    task automatic ins(input logic v, input logic [4:0] rs, rt, rd, input logic urs, urt, rw, mr,
                       input logic [3:0] alu);
        bus.id_valid = v;
        bus.id_rs = rs;
        bus.id_rt = rt;
        bus.id_rdest = rd;
        bus.id_uses_rs = urs;
        bus.id_uses_rt = urt;
        bus.id_regwrite = rw;
        bus.id_memread = mr;
        bus.id_memwrite = 1'b0;
        bus.id_memtoreg = mr;
        bus.id_alu_op = alu;
        bus.id_read_data1 = $urandom;
        bus.id_read_data2 = $urandom;
        bus.id_imm = $urandom;
        bus.id_pc = $urandom;
    endtask

    // One clock: check the same-cycle hold, then the registered outcome against the rules.
    task automatic cyc(input string tag);
        ex_t nxt;
        bit  lu, npend;
        int  nlu, nms;
        #1;
        lu = m.valid && m.mr && m.rdest != 5'd0 && bus.id_valid &&
             ((bus.id_uses_rs && bus.id_rs == m.rdest) || (bus.id_uses_rt && bus.id_rt == m.rdest));
        chk({tag, ":hold"}, bus.hold_upstream, bus.mem_stall || (lu && !bus.flush && !m_pend));
        nxt = m;
        npend = m_pend;
        nlu = m_lu;
        nms = m_ms;
        if (bus.mem_stall) begin
            npend = m_pend || bus.flush;
            nms = (m_ms < CMAX) ? m_ms + 1 : CMAX;
        end else if (bus.flush || m_pend) begin
            nxt = '0;
            npend = 0;
        end else if (lu) begin
            nxt = '0;
            nlu = (m_lu < CMAX) ? m_lu + 1 : CMAX;
        end else begin
            nxt.valid = bus.id_valid;
            nxt.rs = bus.id_rs;
            nxt.rt = bus.id_rt;
            nxt.d1 = bus.id_read_data1;
            nxt.d2 = bus.id_read_data2;
            nxt.imm = bus.id_imm;
            nxt.pc = bus.id_pc;
            nxt.rdest = bus.id_valid ? bus.id_rdest : 5'd0;
            nxt.rw = bus.id_valid && bus.id_regwrite;
            nxt.mr = bus.id_valid && bus.id_memread;
            nxt.mw = bus.id_valid && bus.id_memwrite;
            nxt.mtr = bus.id_valid && bus.id_memtoreg;
            nxt.alu = bus.id_valid ? bus.id_alu_op : '0;
        end
        @(posedge clk);
        #1;
        m = nxt;
        m_pend = npend;
        m_lu = nlu;
        m_ms = nms;
        chk({tag, ":ex"}, dut_ex(), m);
        chk({tag, ":luc"}, bus.load_use_count, m_lu);
        chk({tag, ":msc"}, bus.mem_stall_count, m_ms);
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.mem_stall = 1'b0;
        ins(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD);
        model_reset();
        #12;
        chk("reset:ex", dut_ex(), m);
        chk("reset:luc", bus.load_use_count, 0);
        chk("reset:hold", bus.hold_upstream, 0);
        rst = 1'b0;
        // plain capture
        ins(1, 3, 4, 5, 1, 1, 1, 0, ALU_ADD);
        bus.id_read_data1 = 32'h11;
        bus.id_imm = 32'h20;
        cyc("cap");
        chk("cap:rs", bus.ID_EX_Rs, 3);
        chk("cap:rt", bus.ID_EX_Rt, 4);
        chk("cap:rdest", bus.ID_EX_Rdest, 5);
        chk("cap:rw", bus.ID_EX_RegWrite, 1);
        chk("cap:d1", bus.ID_EX_read_data1, 32'h11);
        chk("cap:imm", bus.ID_EX_imm, 32'h20);
        // load-use bubble
        ins(1, 9, 10, 8, 1, 0, 1, 1, ALU_ADD);
        cyc("lw");
        ins(1, 8, 11, 12, 1, 1, 1, 0, ALU_ADD);
        #1 chk("lu:hold1", bus.hold_upstream, 1);
        cyc("lu_bub");
        chk("lu_bub:valid", bus.ID_EX_valid, 0);
        chk("lu_bub:rdest", bus.ID_EX_Rdest, 0);
        cyc("lu_cap");
        chk("lu_cap:rs", bus.ID_EX_Rs, 8);
        chk("lu_cap:valid", bus.ID_EX_valid, 1);
        chk("lu_cap:luc", bus.load_use_count, 1);
        // no false hazard: load into r0, then a load whose Rdest matches an unused Rt
        ins(1, 2, 3, 0, 1, 0, 0, 1, ALU_ADD);
        cyc("lw0");
        ins(1, 0, 5, 6, 1, 1, 1, 0, ALU_ADD);
        #1 chk("nf0:hold", bus.hold_upstream, 0);
        cyc("nf0");
        chk("nf0:valid", bus.ID_EX_valid, 1);
        ins(1, 2, 3, 8, 1, 0, 1, 1, ALU_ADD);
        cyc("lw8");
        ins(1, 3, 8, 7, 1, 0, 1, 0, ALU_OR);
        #1 chk("nf8:hold", bus.hold_upstream, 0);
        cyc("nf8");
        chk("nf8:valid", bus.ID_EX_valid, 1);
        // mem_stall for three cycles with a flush in the middle one
        ins(1, 1, 2, 3, 1, 1, 1, 0, ALU_SUB);
        cyc("pre_st");
        bus.mem_stall = 1'b1;
        ins(1, 4, 5, 6, 1, 1, 1, 0, ALU_AND);
        cyc("st1");
        bus.flush = 1'b1;
        cyc("st2");
        bus.flush = 1'b0;
        cyc("st3");
        chk("st3:rdest", bus.ID_EX_Rdest, 3);
        chk("st3:msc", bus.mem_stall_count, 3);
        bus.mem_stall = 1'b0;
        cyc("post_st");
        chk("post_st:valid", bus.ID_EX_valid, 0);
        cyc("post_st2");
        chk("post_st2:valid", bus.ID_EX_valid, 1);
        // flush beats load-use
        ins(1, 2, 3, 8, 1, 0, 1, 1, ALU_ADD);
        cyc("lw_f");
        ins(1, 8, 9, 10, 1, 1, 1, 0, ALU_ADD);
        bus.flush = 1'b1;
        #1 chk("fl:hold", bus.hold_upstream, 0);
        cyc("fl");
        bus.flush = 1'b0;
        chk("fl:valid", bus.ID_EX_valid, 0);
        chk("fl:luc", bus.load_use_count, 1);
        // async reset between edges
        ins(1, 4, 5, 6, 1, 1, 1, 0, ALU_SLT);
        cyc("pre_rst");
        chk("pre_rst:valid", bus.ID_EX_valid, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst:ex", dut_ex(), 0);
        chk("arst:msc", bus.mem_stall_count, 0);
        model_reset();
        rst = 1'b0;
        // reset during a stall drops the remembered flush
        bus.mem_stall = 1'b1;
        bus.flush = 1'b1;
        cyc("rst_st");
        bus.flush = 1'b0;
        #3 rst = 1'b1;
        #1 model_reset();
        rst = 1'b0;
        bus.mem_stall = 1'b0;
        ins(1, 7, 8, 9, 1, 1, 1, 0, ALU_ADD);
        cyc("rst_st_cap");
        chk("rst_st_cap:valid", bus.ID_EX_valid, 1);
        // load-use counter saturation
        for (int i = 0; i < 4; i++) begin
            ins(1, 1, 2, 8, 1, 0, 1, 1, ALU_ADD);
            cyc("sat_lw");
            ins(1, 3, 8, 9, 1, 1, 1, 0, ALU_ADD);
            cyc("sat_bub");
            cyc("sat_cap");
        end
        chk("sat:luc", bus.load_use_count, 3);
        // random traffic with a narrow register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            ins(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                4'($urandom));
            bus.id_memwrite = 1'($urandom);
            bus.mem_stall = ($urandom_range(0, 4) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            cyc("rnd");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
